// File: rtl/obj_dma.sv
// obj_dma: object RAM to line-buffer DMA engine.
// Arms on DMA_ON, copies WORDS words after the next vblank rise.
module obj_dma #(
  parameter int WORDS = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          dma_on,
  input  logic          vblank,
  input  logic          bak,
  output logic          brq,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_din,
  output logic [AW-1:0] buf_addr,
  output logic [15:0]   buf_dout,
  output logic          buf_we,
  output logic          busy
);

  localparam logic [AW:0]   LAST = (AW+1)'(WORDS);
  localparam logic [AW-1:0] TOP  = AW'(WORDS - 1);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQ,
    S_COPY,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW:0]   cnt;
  logic [AW-1:0] rd_prev;
  logic [15:0]   hold_d;
  logic          hold_v;
  logic          vb_prev;
  logic          pend;
  logic          step;
  logic          last;
  logic          cnt_nz;

  assign step   = ce & bak & (state == S_COPY);
  assign last   = (cnt == LAST);
  assign cnt_nz = |cnt;

  // Next state; IDLE reacts to dma_on regardless of ce.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (dma_on) state_nx = S_ARM;
      S_ARM:  if (ce && vblank && !vb_prev) state_nx = S_REQ;
      S_REQ:  if (ce && bak) state_nx = S_COPY;
      S_COPY: if (step && last) state_nx = S_DONE;
      S_DONE: if (ce) state_nx = (pend || dma_on) ? S_ARM : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Read counter, write address pipe and stall data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      rd_prev <= '0;
      hold_d  <= '0;
      hold_v  <= 1'b0;
    end else if (ce) begin
      if (state == S_REQ && bak) begin
        cnt    <= '0;
        hold_v <= 1'b0;
      end else if (state == S_COPY) begin
        if (bak) begin
          if (!last) cnt <= cnt + ONE;
          rd_prev <= src_addr;
          hold_v  <= 1'b0;
        end else if (cnt_nz && !hold_v) begin
          // RAM output moves on during a stall; keep the word owed.
          hold_v <= 1'b1;
          hold_d <= src_din;
        end
      end
    end
  end

  // Previous vblank level, sampled on enabled cycles only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vb_prev <= 1'b0;
    else if (ce)   vb_prev <= vblank;
  end

  // Single pending request; strobes while armed are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pend <= 1'b0;
    else if (state == S_DONE && ce)
      pend <= 1'b0;
    else if (dma_on && (state == S_REQ || state == S_COPY ||
                        state == S_DONE))
      pend <= 1'b1;
  end

  assign brq      = (state == S_REQ) || (state == S_COPY);
  assign busy     = (state != S_IDLE);
  assign src_addr = last ? TOP : cnt[AW-1:0];
  assign buf_addr = rd_prev;
  assign buf_we   = step & cnt_nz;
  assign buf_dout = (state != S_COPY) ? 16'h0000 :
                    hold_v ? hold_d : src_din;

endmodule

// File: tb/tb_obj_dma.sv
// tb_obj_dma: randomized self-checking bench for obj_dma.
// Expected writes are the source RAM image in address order.
module tb_obj_dma;

  localparam int WORDS = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic          dma_on;
  logic          vblank;
  logic          bak;
  logic          brq;
  logic [AW-1:0] src_addr;
  logic [15:0]   src_din = 16'h0000;
  logic [AW-1:0] buf_addr;
  logic [15:0]   buf_dout;
  logic          buf_we;
  logic          busy;

  logic [15:0]   src_ram [WORDS];
  logic [AW-1:0] wq_addr [$];
  logic [15:0]   wq_data [$];
  int            wr_cyc  [$];
  int            nwr;
  int            we_nce;
  int            cyc;
  int            ce_div;
  int            n_chk;
  int            n_fail;

  obj_dma #(.WORDS(WORDS), .AW(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .dma_on   (dma_on),
    .vblank   (vblank),
    .bak      (bak),
    .brq      (brq),
    .src_addr (src_addr),
    .src_din  (src_din),
    .buf_addr (buf_addr),
    .buf_dout (buf_dout),
    .buf_we   (buf_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Object RAM: registered read, one ce-cycle latency.
  always @(posedge clk)
    if (ce) src_din <= src_ram[src_addr];

  // Buffer write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (buf_we) begin
      if (!ce) we_nce++;
      else begin
        wq_addr.push_back(buf_addr);
        wq_data.push_back(buf_dout);
        wr_cyc.push_back(cyc);
        nwr++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ce = (cyc % ce_div) == 0;
  endtask

  task automatic ce_step();
    logic c;
    do begin
      c = ce;
      tick();
    end while (!c);
  endtask

  task automatic new_image();
    foreach (src_ram[i]) src_ram[i] = 16'($urandom);
    wq_addr.delete();
    wq_data.delete();
    wr_cyc.delete();
    nwr = 0;
  endtask

  task automatic run_xfer(input string tag, input int vb_dly,
                          input int bak_dly, input int stall_at,
                          input int stall_len, input int pulses,
                          input int busy_end);
    int early;
    int bad_a;
    int bad_d;
    int bad_g;
    int n0;
    bit stalled;
    bit pulsed;
    early   = 0;
    stalled = 0;
    pulsed  = 0;
    new_image();
    vblank = 1'b0;
    dma_on = 1'b1;
    tick();
    dma_on = 1'b0;
    check({tag, "_armed_busy"}, busy, 1);
    for (int i = 0; i < vb_dly; i++) begin
      ce_step();
      if (brq) early++;
    end
    check({tag, "_early_brq"}, early, 0);
    vblank = 1'b1;
    for (int i = 0; i < 8 * ce_div && brq !== 1'b1; i++) tick();
    check({tag, "_brq"}, brq, 1);
    vblank = 1'b0;
    for (int i = 0; i < bak_dly; i++) ce_step();
    check({tag, "_req_hold"}, {brq, nwr[30:0]}, {1'b1, 31'd0});
    bak = 1'b1;
    for (int i = 0; i < 4000 * ce_div && nwr < WORDS; i++) begin
      tick();
      if (stall_len > 0 && !stalled && nwr == stall_at) begin
        stalled = 1;
        bak = 1'b0;
        n0 = nwr;
        for (int k = 0; k < stall_len; k++) ce_step();
        check({tag, "_stall_we"}, nwr - n0, 0);
        check({tag, "_stall_brq"}, brq, 1);
        bak = 1'b1;
      end
      if (pulses > 0 && !pulsed && nwr >= 300) begin
        pulsed = 1;
        for (int k = 0; k < pulses; k++) begin
          dma_on = 1'b1;
          tick();
          dma_on = 1'b0;
          tick();
        end
      end
    end
    bak = 1'b0;
    check({tag, "_nwr"}, nwr, WORDS);
    bad_a = 0;
    bad_d = 0;
    bad_g = 0;
    for (int i = 0; i < wq_addr.size() && i < WORDS; i++) begin
      if (wq_addr[i] !== AW'(i)) bad_a++;
      if (wq_data[i] !== src_ram[i]) bad_d++;
      if (i > 0 && stall_len == 0 &&
          wr_cyc[i] - wr_cyc[i-1] != ce_div) bad_g++;
    end
    check({tag, "_addr_errs"}, bad_a, 0);
    check({tag, "_data_errs"}, bad_d, 0);
    check({tag, "_gap_errs"}, bad_g, 0);
    check({tag, "_done_brq"}, brq, 0);
    check({tag, "_done_busy"}, busy, 1);
    ce_step();
    check({tag, "_end_busy"}, busy, busy_end);
    check({tag, "_end_brq"}, brq, 0);
  endtask

  initial begin
    int n0;
    n_chk   = 0;
    n_fail  = 0;
    nwr     = 0;
    we_nce  = 0;
    cyc     = 0;
    ce_div  = 1;
    ce      = 1'b1;
    reset_n = 1'b0;
    dma_on  = 1'b0;
    vblank  = 1'b0;
    bak     = 1'b0;
    foreach (src_ram[i]) src_ram[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_brq", brq, 0);
    check("rst_busy", busy, 0);
    check("rst_we", buf_we, 0);
    check("rst_src_addr", src_addr, 0);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_dout", buf_dout, 0);
    reset_n = 1'b1;
    repeat (4) tick();
    vblank = 1'b1;
    bak = 1'b1;
    repeat (4) tick();
    check("idle_no_start", {busy, brq}, 0);
    vblank = 1'b0;
    bak = 1'b0;
    tick();

    run_xfer("basic", 10, 2, -1, 0, 0, 0);
    run_xfer("stall", $urandom_range(2, 12), $urandom_range(0, 4),
             100, 5, 0, 0);
    run_xfer("stall_rnd", $urandom_range(2, 12), $urandom_range(0, 4),
             $urandom_range(1, WORDS - 1), $urandom_range(1, 9), 0, 0);

    run_xfer("pend", $urandom_range(2, 12), $urandom_range(0, 4),
             -1, 0, 3, 1);
    repeat (20) tick();
    check("pend_wait_brq", brq, 0);
    check("pend_wait_busy", busy, 1);
    run_xfer("pend2", $urandom_range(2, 12), 1, -1, 0, 0, 0);

    vblank = 1'b1;
    dma_on = 1'b1;
    tick();
    dma_on = 1'b0;
    repeat (20) tick();
    check("blank_no_brq", brq, 0);
    check("blank_busy", busy, 1);
    run_xfer("blank", $urandom_range(2, 12), 2, -1, 0, 0, 0);

    ce_div = 4;
    run_xfer("ce4", $urandom_range(2, 8), $urandom_range(0, 3),
             -1, 0, 0, 0);
    ce_div = 1;
    tick();

    new_image();
    dma_on = 1'b1;
    tick();
    dma_on = 1'b0;
    repeat (3) tick();
    vblank = 1'b1;
    for (int i = 0; i < 8 && !brq; i++) tick();
    bak = 1'b1;
    for (int i = 0; i < 2000 && nwr < 200; i++) tick();
    check("rst_mid_nwr", nwr, 200);
    reset_n = 1'b0;
    #1;
    check("rst_mid_brq", brq, 0);
    check("rst_mid_busy", busy, 0);
    n0 = nwr;
    repeat (3) tick();
    reset_n = 1'b1;
    vblank = 1'b0;
    repeat (3) tick();
    vblank = 1'b1;
    repeat (6) tick();
    check("rst_mid_no_wr", nwr - n0, 0);
    check("rst_mid_idle", {busy, brq}, 0);
    bak = 1'b0;
    vblank = 1'b0;
    tick();
    run_xfer("post_rst", $urandom_range(2, 12), 2, -1, 0, 0, 0);

    check("we_without_ce", we_nce, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
